// File: rtl/alu_pkg.sv
// Shared widths, opcode and flag definitions for the practice CPU ALU.
package alu_pkg;
    localparam int ALU_INOUT_WIDTH  = 8;
    localparam int ALU_OPER_WIDTH   = 4;
    localparam int PROC_FLAGS_WIDTH = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [ALU_OPER_WIDTH-1:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBC = 4'd3,
        OP_CMP = 4'd4,
        OP_AND = 4'd5,
        OP_ORR = 4'd6,
        OP_XOR = 4'd7,
        OP_LSL = 4'd8,
        OP_LSR = 4'd9,
        OP_ASR = 4'd10,
        OP_ROL = 4'd11,
        OP_ROR = 4'd12
    } alu_oper_t;

    typedef enum logic [2:0] {
        SH_LSL = 3'd0,
        SH_LSR = 3'd1,
        SH_ASR = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_mode_t;
endpackage

// File: rtl/alu_shifter.sv
// Combinational 8-bit barrel shifter/rotator; a zero amount passes the operand
// and the carry straight through.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [ALU_INOUT_WIDTH-1:0] a_i,
    input  logic [2:0]                 k_i,
    input  shift_mode_t                mode_i,
    input  logic                       c_i,
    output logic [ALU_INOUT_WIDTH-1:0] res_o,
    output logic                       c_o
);
    logic [ALU_INOUT_WIDTH:0]   wide;
    logic [ALU_INOUT_WIDTH-1:0] rot;
    logic [3:0]                 k_inv;

    assign k_inv = 4'd8 - {1'b0, k_i};

    // The extra ninth bit catches the last bit shifted out, which becomes C.
    always_comb begin
        wide  = '0;
        rot   = '0;
        res_o = a_i;
        c_o   = c_i;
        if (k_i != 3'd0) begin
            case (mode_i)
                SH_LSL: begin
                    wide  = {1'b0, a_i} << k_i;
                    res_o = wide[7:0];
                    c_o   = wide[8];
                end
                SH_LSR: begin
                    wide  = {a_i, 1'b0} >> k_i;
                    res_o = wide[8:1];
                    c_o   = wide[0];
                end
                SH_ASR: begin
                    wide  = $signed({a_i, 1'b0}) >>> k_i;
                    res_o = wide[8:1];
                    c_o   = wide[0];
                end
                SH_ROL: begin
                    rot   = (a_i << k_i) | (a_i >> k_inv);
                    res_o = rot;
                    c_o   = rot[0];
                end
                SH_ROR: begin
                    rot   = (a_i >> k_i) | (a_i << k_inv);
                    res_o = rot;
                    c_o   = rot[7];
                end
                default: begin
                    res_o = a_i;
                    c_o   = c_i;
                end
            endcase
        end
    end
endmodule

// File: rtl/cpu_alu.sv
// Registered 8-bit ALU: adder, logic ops, shifter, N/V/C/Z generation and a
// single output register stage.
module cpu_alu
    import alu_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ALU_OPER_WIDTH-1:0]   oper,
    input  logic [ALU_INOUT_WIDTH-1:0]  a_in,
    input  logic [ALU_INOUT_WIDTH-1:0]  b_in,
    input  logic [PROC_FLAGS_WIDTH-1:0] proc_flags_in,
    output logic [ALU_INOUT_WIDTH-1:0]  out,
    output logic [PROC_FLAGS_WIDTH-1:0] proc_flags_out
);
    alu_oper_t                    op;
    shift_mode_t                  sh_mode;
    logic                         is_sub;
    logic                         carry_in;
    logic [ALU_INOUT_WIDTH-1:0]   b_eff;
    logic [ALU_INOUT_WIDTH:0]     sum;
    logic                         ovf;
    logic [ALU_INOUT_WIDTH-1:0]   sh_res;
    logic                         sh_c;
    logic [ALU_INOUT_WIDTH-1:0]   out_d, out_q, nz_src;
    logic [PROC_FLAGS_WIDTH-1:0]  flags_d, flags_q;
    logic                         update_nz;

    assign op = alu_oper_t'(oper);

    // Subtraction is a + ~b + carry_in, so one adder serves every arithmetic op.
    assign is_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
    assign b_eff  = is_sub ? ~b_in : b_in;

    always_comb begin
        carry_in = 1'b0;
        case (op)
            OP_ADC, OP_SBC: carry_in = proc_flags_in[FLAG_C];
            OP_SUB, OP_CMP: carry_in = 1'b1;
            default:        carry_in = 1'b0;
        endcase
    end

    assign sum = {1'b0, a_in} + {1'b0, b_eff} + {8'd0, carry_in};
    assign ovf = (a_in[7] == b_eff[7]) && (sum[7] != a_in[7]);

    always_comb begin
        sh_mode = SH_LSL;
        case (op)
            OP_LSR:  sh_mode = SH_LSR;
            OP_ASR:  sh_mode = SH_ASR;
            OP_ROL:  sh_mode = SH_ROL;
            OP_ROR:  sh_mode = SH_ROR;
            default: sh_mode = SH_LSL;
        endcase
    end

    alu_shifter u_shifter (
        .a_i    (a_in),
        .k_i    (b_in[2:0]),
        .mode_i (sh_mode),
        .c_i    (proc_flags_in[FLAG_C]),
        .res_o  (sh_res),
        .c_o    (sh_c)
    );

    // nz_src is separate from out_d because cmp reports the difference in N/Z
    // while passing A through on the data output.
    always_comb begin
        out_d     = a_in;
        flags_d   = proc_flags_in;
        nz_src    = a_in;
        update_nz = 1'b1;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                out_d           = (op == OP_CMP) ? a_in : sum[7:0];
                nz_src          = sum[7:0];
                flags_d[FLAG_C] = sum[8];
                flags_d[FLAG_V] = ovf;
            end
            OP_AND: begin
                out_d  = a_in & b_in;
                nz_src = a_in & b_in;
            end
            OP_ORR: begin
                out_d  = a_in | b_in;
                nz_src = a_in | b_in;
            end
            OP_XOR: begin
                out_d  = a_in ^ b_in;
                nz_src = a_in ^ b_in;
            end
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
                out_d           = sh_res;
                nz_src          = sh_res;
                flags_d[FLAG_C] = sh_c;
            end
            default: update_nz = 1'b0;
        endcase
        if (update_nz) begin
            flags_d[FLAG_N] = nz_src[7];
            flags_d[FLAG_Z] = (nz_src == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign out            = out_q;
    assign proc_flags_out = flags_q;
endmodule

// File: tb/tb_cpu_alu.sv
// Bench for cpu_alu: directed cases plus a randomized opcode sweep checked
// against an integer-arithmetic reference model.
module tb_cpu_alu;
    logic       clk;
    logic       rst;
    logic [3:0] oper;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [3:0] proc_flags_in;
    logic [7:0] out;
    logic [3:0] proc_flags_out;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_alu dut (
        .clk            (clk),
        .rst            (rst),
        .oper           (oper),
        .a_in           (a_in),
        .b_in           (b_in),
        .proc_flags_in  (proc_flags_in),
        .out            (out),
        .proc_flags_out (proc_flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int put_flag(input int f, input int bit_i, input int val);
        return (f & ~(1 << bit_i)) | ((val != 0 ? 1 : 0) << bit_i);
    endfunction

    // Flags: bit0 Z, bit1 C, bit2 V, bit3 N. Arithmetic done on plain ints.
    function automatic void model(input int op, input int a, input int b, input int f,
                                  output int r, output int nf);
        int c, k, cin, s, sv, sa, sb, nzv;
        c   = (f >> 1) & 1;
        k   = b & 7;
        sa  = (a > 127) ? a - 256 : a;
        sb  = (b > 127) ? b - 256 : b;
        r   = a;
        nf  = f;
        nzv = a;
        case (op)
            0, 1: begin
                cin = (op == 1) ? c : 0;
                s   = a + b + cin;
                sv  = sa + sb + cin;
                r   = s & 255;
                nzv = r;
                nf  = put_flag(nf, 1, s > 255);
                nf  = put_flag(nf, 2, sv < -128 || sv > 127);
            end
            2, 3, 4: begin
                cin = (op == 3) ? c : 1;
                s   = a - b - 1 + cin;
                sv  = sa - sb - 1 + cin;
                nzv = s & 255;
                r   = (op == 4) ? a : (s & 255);
                nf  = put_flag(nf, 1, s >= 0);
                nf  = put_flag(nf, 2, sv < -128 || sv > 127);
            end
            5: begin r = a & b; nzv = r; end
            6: begin r = a | b; nzv = r; end
            7: begin r = a ^ b; nzv = r; end
            8, 9, 10, 11, 12: begin
                if (k != 0) begin
                    case (op)
                        8:  begin r = (a << k) & 255; nf = put_flag(nf, 1, (a >> (8 - k)) & 1); end
                        9:  begin r = a >> k; nf = put_flag(nf, 1, (a >> (k - 1)) & 1); end
                        10: begin r = (sa >>> k) & 255; nf = put_flag(nf, 1, (a >> (k - 1)) & 1); end
                        11: begin r = ((a << k) | (a >> (8 - k))) & 255; nf = put_flag(nf, 1, r & 1); end
                        default: begin r = ((a >> k) | (a << (8 - k))) & 255; nf = put_flag(nf, 1, (r >> 7) & 1); end
                    endcase
                end
                nzv = r;
            end
            default: return;
        endcase
        nf = put_flag(nf, 3, (nzv >> 7) & 1);
        nf = put_flag(nf, 0, nzv == 0);
    endfunction

    task automatic drive(input int op, input int a, input int b, input int f);
        oper          = 4'(op);
        a_in          = 8'(a);
        b_in          = 8'(b);
        proc_flags_in = 4'(f);
    endtask

    task automatic directed(input string name, input int op, input int a, input int b,
                            input int f, input int exp_out, input int exp_flags);
        drive(op, a, b, f);
        @(posedge clk); #1;
        $display("%s: op=%0d a=%02h b=%02h f=%h -> out=%02h flags=%h",
                 name, op, a, b, f, out, proc_flags_out);
        check({name, " out"}, out, 8'(exp_out));
        check({name, " flags"}, {4'd0, proc_flags_out}, 8'(exp_flags));
    endtask

    task automatic modeled(input int op, input int a, input int b, input int f);
        int r, nf;
        model(op, a, b, f, r, nf);
        drive(op, a, b, f);
        @(posedge clk); #1;
        check($sformatf("op%0d a=%02h b=%02h f=%h out", op, a, b, f), out, 8'(r));
        check($sformatf("op%0d a=%02h b=%02h f=%h flags", op, a, b, f),
              {4'd0, proc_flags_out}, 8'(nf));
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 8'h7F, 8'h01, 0);
        @(posedge clk);
        @(posedge clk); #1;
        $display("reset: out=%02h flags=%h", out, proc_flags_out);
        check("reset out", out, 8'h00);
        check("reset flags", {4'd0, proc_flags_out}, 8'h00);
        rst = 1'b0;

        directed("add ovf",      0, 8'h7F, 8'h01, 4'h0, 8'h80, 4'hC);
        directed("adc carry",    1, 8'hFF, 8'h00, 4'h2, 8'h00, 4'h3);
        directed("sbc borrow",   3, 8'h00, 8'h01, 4'h2, 8'hFF, 4'h8);
        directed("cmp equal",    4, 8'h05, 8'h05, 4'h0, 8'h05, 4'h3);
        directed("cmp less",     4, 8'h03, 8'h05, 4'h0, 8'h03, 4'h8);
        directed("and keep cv",  5, 8'hF0, 8'h0F, 4'h6, 8'h00, 4'h7);
        directed("lsl 1",        8, 8'h81, 8'h01, 4'h0, 8'h02, 4'h2);
        directed("asr 3",       10, 8'h80, 8'h03, 4'h0, 8'hF0, 4'h8);
        directed("rol 1",       11, 8'h81, 8'h01, 4'h0, 8'h03, 4'h2);
        directed("ror 1",       12, 8'h01, 8'h01, 4'h0, 8'h80, 4'hA);
        directed("lsr 0",        9, 8'h55, 8'hF8, 4'h2, 8'h55, 4'h2);
        directed("reserved 13", 13, 8'h3C, 8'h77, 4'h9, 8'h3C, 4'h9);

        // Every opcode, every A, b_in[1:0] and C swept; other bits randomized.
        for (int op = 0; op < 16; op++)
            for (int a = 0; a < 256; a++)
                for (int bs = 0; bs < 4; bs++)
                    for (int c = 0; c < 2; c++)
                        modeled(op, a, int'(($urandom & 32'hFC) | bs),
                                int'(($urandom & 32'hD) | (c << 1)));

        for (int i = 0; i < 2000; i++)
            modeled(int'($urandom_range(0, 15)), int'($urandom & 32'hFF),
                    int'($urandom & 32'hFF), int'($urandom & 32'hF));

        rst = 1'b1;
        drive(1, 8'hFF, 8'hFF, 4'hF);
        @(posedge clk); #1;
        check("mid reset out", out, 8'h00);
        check("mid reset flags", {4'd0, proc_flags_out}, 8'h00);
        rst = 1'b0;
        modeled(2, 8'h10, 8'h20, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
